// File: rtl/parse_act_ram_arbiter_pkg.sv
// Shared constants and helpers for the parse-action RAM arbiter.
//   DefNumReq / DefAddrW / DefDataW / DefRamRdLat : default configuration
//   RespLat       : grant-to-response latency for the default RAM latency
//   onehot_to_idx : index of the set bit in a one-hot vector (up to 8 bits)
package parser_ctrl_pkg;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefAddrW    = 5;
  localparam int unsigned DefDataW    = 160;
  localparam int unsigned DefRamRdLat = 1;
  localparam int unsigned RespLat     = DefRamRdLat + 2;

  function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/parse_act_ram_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i      : request vector
//   ptr_i      : highest-priority index for this cycle
//   gnt_o      : one-hot grant (first request at or above ptr_i, wrapping)
//   next_ptr_o : index after the granted one, or ptr_i when nothing is granted
//   any_o      : a grant was made
// The pointer register lives in the instantiating module.
module rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] next_ptr_o,
  output logic                      any_o
);

  localparam int unsigned PtrW = $clog2(NumReq);

  always_comb begin
    int unsigned idx;
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    any_o      = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(ptr_i) + k) % NumReq;
      if (!any_o && req_i[idx[PtrW-1:0]]) begin
        any_o                   = 1'b1;
        gnt_o[idx[PtrW-1:0]]    = 1'b1;
        next_ptr_o              = PtrW'((idx + 1) % NumReq);
      end
    end
  end

endmodule

// File: rtl/parse_act_ram_arbiter.sv
// Shares the parse-action RAM read port between NUM_REQ parsers (round robin) and
// drives config writes onto the RAM write port.
//   req_valid/req_addr/req_ready : per-parser read request, combinational one-hot grant
//   resp_valid/resp_id/resp_data : read response, RAM_RD_LAT+2 cycles after the grant
//   cfg_wr_*                     : config write, accepted while cfg_wr_ready is high
//   ram_wea/ram_addra/ram_dina   : registered RAM port A (write)
//   ram_addrb/ram_doutb          : registered RAM port B address and returned data
//   init_done                    : RAM usable
// Build option PARSE_ACT_INIT_CLR_EN: zero the whole RAM after reset before use.
module parse_act_ram_arbiter
  import parser_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned RAM_RD_LAT = DefRamRdLat
) (
  input  logic                      axis_clk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [NUM_REQ-1:0]        resp_id,
  output logic [DATA_W-1:0]         resp_data,
  input  logic                      cfg_wr_en,
  input  logic [ADDR_W-1:0]         cfg_wr_addr,
  input  logic [DATA_W-1:0]         cfg_wr_data,
  output logic                      cfg_wr_ready,
  output logic                      ram_wea,
  output logic [ADDR_W-1:0]         ram_addra,
  output logic [DATA_W-1:0]         ram_dina,
  output logic [ADDR_W-1:0]         ram_addrb,
  input  logic [DATA_W-1:0]         ram_doutb,
  output logic                      init_done
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic                 active_q;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any, grant_en;
  logic [ADDR_W-1:0]    gnt_addr;
  logic                 sweep_wr;
  logic [ADDR_W-1:0]    sweep_addr;
  logic                 wea_d;
  logic [ADDR_W-1:0]    addra_d;
  logic [DATA_W-1:0]    dina_d;
  logic                 collision;

  // Read pipeline: stage 0 is the cycle ram_addrb holds the new read.
  logic [RAM_RD_LAT:0]  vld_q;
  logic [NUM_REQ-1:0]   id_q       [RAM_RD_LAT+1];
  logic [RAM_RD_LAT:1]  byp_q;
  logic [DATA_W-1:0]    byp_data_q [1:RAM_RD_LAT];

  rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_rr_arbiter (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (gnt),
    .next_ptr_o (rr_ptr_d),
    .any_o      (gnt_any)
  );

  assign grant_en     = active_q & init_done & gnt_any;
  assign req_ready    = grant_en ? gnt : '0;
  assign gnt_addr     = req_addr[onehot_to_idx(8'(gnt))*ADDR_W +: ADDR_W];
  assign cfg_wr_ready = init_done;

`ifdef PARSE_ACT_INIT_CLR_EN
  // Counter runs 0..2^ADDR_W; the MSB marks the sweep as finished.
  logic [ADDR_W:0] sweep_cnt_q;
  logic            init_done_q;

  assign sweep_wr   = ~sweep_cnt_q[ADDR_W];
  assign sweep_addr = sweep_cnt_q[ADDR_W-1:0];
  assign init_done  = init_done_q;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      sweep_cnt_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (sweep_wr) sweep_cnt_q <= sweep_cnt_q + (ADDR_W+1)'(1);
      init_done_q <= sweep_cnt_q[ADDR_W];
    end
  end
`else
  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
  assign init_done  = 1'b1;
`endif

  always_comb begin
    wea_d   = 1'b0;
    addra_d = ram_addra;
    dina_d  = ram_dina;
    if (sweep_wr) begin
      wea_d   = 1'b1;
      addra_d = sweep_addr;
      dina_d  = '0;
    end else if (cfg_wr_en && init_done) begin
      wea_d   = 1'b1;
      addra_d = cfg_wr_addr;
      dina_d  = cfg_wr_data;
    end
  end

  // A write landing while ram_addrb holds a fresh read at the same address would be
  // missed by the RAM read; forward the write data to that response instead.
  assign collision = vld_q[0] & ram_wea & (ram_addra == ram_addrb);

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      active_q   <= 1'b0;
      rr_ptr_q   <= '0;
      ram_wea    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      ram_addrb  <= '0;
      vld_q      <= '0;
      byp_q      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      for (int unsigned j = 0; j <= RAM_RD_LAT; j++) id_q[j] <= '0;
      for (int unsigned j = 1; j <= RAM_RD_LAT; j++) byp_data_q[j] <= '0;
    end else begin
      active_q  <= 1'b1;
      ram_wea   <= wea_d;
      ram_addra <= addra_d;
      ram_dina  <= dina_d;
      if (grant_en) begin
        rr_ptr_q  <= rr_ptr_d;
        ram_addrb <= gnt_addr;
      end
      vld_q[0] <= grant_en;
      id_q[0]  <= req_ready;
      for (int unsigned j = 1; j <= RAM_RD_LAT; j++) begin
        vld_q[j] <= vld_q[j-1];
        id_q[j]  <= id_q[j-1];
      end
      byp_q[1]      <= collision;
      byp_data_q[1] <= ram_dina;
      for (int unsigned j = 2; j <= RAM_RD_LAT; j++) begin
        byp_q[j]      <= byp_q[j-1];
        byp_data_q[j] <= byp_data_q[j-1];
      end
      resp_valid <= vld_q[RAM_RD_LAT];
      if (vld_q[RAM_RD_LAT]) begin
        resp_id   <= id_q[RAM_RD_LAT];
        resp_data <= byp_q[RAM_RD_LAT] ? byp_data_q[RAM_RD_LAT] : ram_doutb;
      end
    end
  end

endmodule

// File: tb/tb_parse_act_ram_arbiter.sv
module tb_parse_act_ram_arbiter;
  import parser_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 160;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [NR-1:0] id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic              axis_clk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready;
  logic              resp_valid;
  logic [NR-1:0]     resp_id;
  logic [DW-1:0]     resp_data;
  logic              cfg_wr_en;
  logic [AW-1:0]     cfg_wr_addr;
  logic [DW-1:0]     cfg_wr_data;
  logic              cfg_wr_ready;
  logic              ram_wea;
  logic [AW-1:0]     ram_addra;
  logic [DW-1:0]     ram_dina;
  logic [AW-1:0]     ram_addrb;
  logic [DW-1:0]     ram_doutb;
  logic              init_done;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [NR-1:0] pend;
  logic [AW-1:0] paddr [NR];
  logic [DW-1:0] mdl [DEPTH];   // reference view of the RAM contents
  logic [DW-1:0] mem [DEPTH];   // RAM behind the DUT
  int            m_ptr;
  bit            m_active;
  bit            m_init;
  int            rel_cyc;
  int            sw_idx;

  parse_act_ram_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RAM_RD_LAT (1)
  ) dut (
    .axis_clk     (axis_clk),
    .aresetn      (aresetn),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_ready (cfg_wr_ready),
    .ram_wea      (ram_wea),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_addrb    (ram_addrb),
    .ram_doutb    (ram_doutb),
    .init_done    (init_done)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  // Read-first RAM, one cycle read latency.
  always @(posedge axis_clk) begin
    ram_doutb <= mem[ram_addrb];
    if (ram_wea) mem[ram_addra] <= ram_dina;
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge axis_clk) begin
    exp_t e;
    if (aresetn === 1'b1) begin
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL resp_unexpected: got resp_valid=1 id=%b expected no response (cycle %0d)",
                   resp_id, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_id", DW'(resp_id), DW'(e.id));
          chk("resp_data", resp_data, e.data);
          chk("resp_cycle", DW'(cyc), DW'(e.due));
        end
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL resp_missing: got no response expected id=%b due cycle %0d",
                 sb[0].id, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

`ifdef PARSE_ACT_INIT_CLR_EN
  always @(negedge axis_clk) begin
    if (aresetn === 1'b1 && ram_wea === 1'b1 && sw_idx < DEPTH) begin
      chk("sweep_addr", DW'(ram_addra), DW'(sw_idx));
      chk("sweep_data", ram_dina, '0);
      sw_idx++;
    end
  end
`endif

  // One clock of stimulus; reference model decides grant and expected read data.
  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [NR-1:0] exp_rdy;
    int            g;
    @(posedge axis_clk);
    #1;
    req_valid = pend;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = paddr[i];
    cfg_wr_en   = we;
    cfg_wr_addr = wa;
    cfg_wr_data = wd;
`ifdef PARSE_ACT_INIT_CLR_EN
    m_init = (cyc >= rel_cyc + DEPTH + 1);
    if (cyc == rel_cyc + DEPTH + 1) chk("sweep_count", DW'(sw_idx), DW'(DEPTH));
`endif
    #2;
    g = -1;
    if (m_active && m_init) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && pend[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    chk("cfg_wr_ready", DW'(cfg_wr_ready), DW'(m_init));
    chk("init_done", DW'(init_done), DW'(m_init));
    // A write accepted in the grant cycle is visible to that read; later ones are not.
    if (we && m_init) mdl[wa] = wd;
    if (g >= 0) begin
      sb.push_back('{id: exp_rdy, data: mdl[paddr[g]], due: cyc + int'(RespLat)});
      pend[g] = 1'b0;
      m_ptr   = (g + 1) % NR;
    end
    m_active = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0);
  endtask

  task automatic request(input int id, input logic [AW-1:0] a);
    pend[id]  = 1'b1;
    paddr[id] = a;
  endtask

  task automatic do_reset(input int n);
    @(posedge axis_clk);
    #1;
    aresetn  = 1'b0;
    cfg_wr_en = 1'b0;
    sb.delete();
    m_active = 1'b0;
    m_ptr    = 0;
    #2;
    chk("rst_resp_valid", DW'(resp_valid), '0);
    chk("rst_resp_id", DW'(resp_id), '0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_ram_wea", DW'(ram_wea), '0);
    chk("rst_ram_addra", DW'(ram_addra), '0);
    chk("rst_ram_dina", ram_dina, '0);
    chk("rst_ram_addrb", DW'(ram_addrb), '0);
    repeat (n) begin
      @(posedge axis_clk);
      #3;
      chk("rst_req_ready", DW'(req_ready), '0);
    end
    @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    rel_cyc = cyc;
    sw_idx  = 0;
`ifdef PARSE_ACT_INIT_CLR_EN
    m_init = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
`endif
    #2;
    chk("release_req_ready", DW'(req_ready), '0);
    m_active = 1'b1;
  endtask

  task automatic wait_init();
    for (int i = 0; i < DEPTH + 8 && !m_init; i++) idle(1);
  endtask

  initial begin
    aresetn     = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    pend        = '0;
    m_init      = 1'b1;
    m_active    = 1'b0;
    m_ptr       = 0;
    rel_cyc     = 0;
    sw_idx      = 0;
    for (int i = 0; i < NR; i++) paddr[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = rand_word();
      mem[i] <= mdl[i];
    end

    do_reset(2);
    wait_init();

    // All requesters busy from rr_ptr=0: grants 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NR; i++) if (!pend[i]) request(i, AW'($urandom_range(0, DEPTH - 1)));
      idle(1);
    end
    for (int c = 0; c < NR && pend != '0; c++) idle(1);
    idle(4);

    // Single requester 2 reading a known entry.
    step(1'b1, 5'd5, DW'(160'hABCD));
    idle(1);
    request(2, 5'd5);
    idle(5);

    // Write lands in the same cycle as the read address: read sees new data.
    step(1'b1, 5'd7, DW'(160'h11));
    idle(1);
    request(0, 5'd7);
    step(1'b1, 5'd7, DW'(160'h55));
    idle(1);
    request(1, 5'd7);
    idle(5);

    // Write one cycle after the read address: read sees old data.
    step(1'b1, 5'd3, DW'(160'h22));
    idle(1);
    request(3, 5'd3);
    idle(1);
    step(1'b1, 5'd3, DW'(160'h99));
    request(3, 5'd3);
    idle(5);

    // Random traffic over a narrow address range to provoke collisions.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) request(i, AW'($urandom_range(0, 7)));
      end
      step($urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), rand_word());
    end
    for (int c = 0; c < NR && pend != '0; c++) idle(1);
    idle(5);

    // Reset with reads in flight: nothing may come back, first grant goes to 0.
    pend = '1;
    idle(2);
    pend = '1;
    do_reset(2);
    wait_init();
    for (int c = 0; c < NR && pend != '0; c++) idle(1);
    idle(6);

    chk("scoreboard_empty", DW'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/parse_act_ram_arbiter.md
Name: parse_act_ram_arbiter

Overview:
Shares the single read port of the parse-action RAM between NUM_REQ parser instances using round-robin arbitration. Routes control-path configuration writes onto the RAM write port. Substitutes write data when a read and a write hit the same address in the same cycle. Sits between the parser array and the parse-action RAM, replacing each parser's direct RAM connection.

Parameters:
NUM_REQ, 4, number of parser requesters (2..8)
ADDR_W, 5, RAM address width (depth = 2^ADDR_W)
DATA_W, 160, parse-action entry width
RAM_RD_LAT, 1, RAM port-B read latency in cycles (1..3)

Ports:
axis_clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W+:ADDR_W]
req_ready  out  NUM_REQ  one-hot grant, combinational
resp_valid  out  1  response strobe
resp_id  out  NUM_REQ  one-hot owner of response
resp_data  out  DATA_W  entry read
cfg_wr_en  in  1  config write strobe
cfg_wr_addr  in  ADDR_W  config write address
cfg_wr_data  in  DATA_W  config write data
cfg_wr_ready  out  1  write accepted when high
ram_wea  out  1  RAM port-A write enable
ram_addra  out  ADDR_W  RAM port-A address
ram_dina  out  DATA_W  RAM port-A data
ram_addrb  out  ADDR_W  RAM port-B address
ram_doutb  in  DATA_W  RAM port-B data
init_done  out  1  RAM ready for use

Behaviour:
- Reset values, asynchronous, applied while aresetn is low:
  - all registered outputs are 0: resp_valid, resp_id, resp_data, ram_wea, ram_addra, ram_dina, ram_addrb.
  - rr_ptr is 0.
  - the internal active flag is 0, which forces req_ready to 0.
- Reset is released synchronously. The active flag rises on the first clock edge after release.
- Arbitration:
  - req_ready[g] is 1 for exactly one g: the first index with req_valid high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is 0 for all requesters when none is valid, when the active flag is 0, or when init_done is 0.
  - After a grant, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
  - A requester must hold req_valid and req_addr stable until it sees req_ready.
- Read pipeline, for a grant in cycle T:
  - ram_addrb is registered with req_addr[g] at the edge ending T.
  - The RAM output is sampled RAM_RD_LAT cycles later.
  - resp_valid, resp_id = 1<<g and resp_data are registered one cycle after that.
  - Total latency = RAM_RD_LAT+2 cycles. With the default, a grant in T gives a response in T+3.
- Responses have no back-pressure. One grant per cycle is allowed, so up to RAM_RD_LAT+2 reads are in flight.
- resp_valid is a single-cycle pulse. resp_data holds its value between pulses.
- Write path:
  - cfg_wr_ready = init_done.
  - An accepted write registers ram_wea=1, ram_addra and ram_dina on the next edge. ram_wea is a one-cycle pulse.
  - A write arriving while cfg_wr_ready=0 is dropped.
- Collision:
  - Collision condition: in the cycle where ram_wea=1 and ram_addrb==ram_addra, with ram_addrb holding a newly issued read.
  - The response for that read returns the ram_dina value, not ram_doutb.
  - A write landing after the read address was registered is not reflected in that read: the read is ordered first.
- Writes and reads proceed concurrently with no mutual stalls.
- Reset mid-operation: all in-flight responses are discarded and no resp_valid pulse follows for them.

Optional Feature:
PARSE_ACT_INIT_CLR_EN
- Defined:
  - After reset, an internal sweep writes all-zero data to addresses 0..2^ADDR_W-1, one per cycle, driving ram_wea/ram_addra/ram_dina.
  - During the sweep, init_done=0, which forces req_ready=0 and cfg_wr_ready=0.
  - init_done rises the cycle after the last sweep write. Its reset value is 0.
- Not defined: init_done is constant 1 and no sweep occurs.

Decomposition:
- Package parser_ctrl_pkg: default ADDR_W/DATA_W/NUM_REQ constants, a response-latency constant (RAM_RD_LAT+2), and an onehot-to-index function.
- Sub-module rr_arbiter (NUM_REQ): takes req and ptr, outputs a one-hot grant and a next pointer. It is purely combinational; the pointer register lives in the parent.

Test Plan:
1. Requester 2 only, addr 5, RAM entry 5 preloaded with 0xABCD (zero-extended to DATA_W) → req_ready=0100 in T; resp_valid in T+3 with resp_id=0100 and resp_data=0xABCD.
2. All 4 requesters hold req_valid for 8 cycles, rr_ptr=0 → grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
3. cfg_wr_en at addr 7 with data 0x55 in the same cycle that ram_addrb registers 7 (entry 7 old=0x11) → that read returns 0x55; the next read of 7 returns 0x55.
4. Write to addr 3 lands one cycle after read addr 3 is registered (old=0x22) → the response returns 0x22.
5. Assert aresetn low with 2 reads in flight → no resp_valid pulses after reset; all outputs 0; first grant after release goes to requester 0.
6. PARSE_ACT_INIT_CLR_EN defined, ADDR_W=5 → exactly 32 ram_wea pulses with addresses 0..31 and zero data; init_done rises 1 cycle later; req_ready held low until then.
